// File: rtl/regfile_writeback_scheduler.sv
// regfile_writeback_scheduler
//
// Purpose:
//   Sits between the issue stage and the two result producers (ALU and
//   load/store unit). It drives the single write port of a 32x32 register
//   file. The block does four things:
//     - keeps a per-register busy scoreboard;
//     - stalls issue on RAW and WAW hazards;
//     - limits the number of in-flight register writes;
//     - arbitrates the two writeback streams onto the one write port.
//   The write port is registered, so a grant in cycle N is written during
//   cycle N+1. An instruction issued in cycle N+2 sees the new value through
//   the register file's 1-cycle registered read.
//
// Parameters:
//   MAX_OUTSTANDING  max in-flight register writes (1..15)
//   PRIORITY_MODE    0 = round-robin ALU/LSU, 1 = fixed priority (LSU wins)
//
// Ports:
//   clock, reset_n                  clock (rising edge), async active-low reset
//   issue_valid/issue_ready         issue handshake
//   issue_rs1/rs2/rd/rd_write       instruction register fields
//   alu_wb_valid/ready/rd/data      ALU writeback stream
//   lsu_wb_valid/ready/rd/data      load/store writeback stream
//   write_enable/write_select/data_in   register file write port
//   busy                            scoreboard (bit 0 always 0)
//   outstanding                     in-flight write count
//   wb_error                        sticky: write to a register not marked busy
module regfile_writeback_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int PRIORITY_MODE   = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_write,
  input  logic        alu_wb_valid,
  output logic        alu_wb_ready,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic        lsu_wb_valid,
  output logic        lsu_wb_ready,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  output logic        write_enable,
  output logic [4:0]  write_select,
  output logic [31:0] data_in,
  output logic [31:0] busy,
  output logic [3:0]  outstanding,
  output logic        wb_error
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [31:0] busy_reg, busy_next;
  logic [3:0]  outstanding_reg, outstanding_next;
  logic        rr_ptr_reg, rr_ptr_next;      // 0 = ALU next, 1 = LSU next
  logic        write_enable_reg;
  logic [4:0]  write_select_reg;
  logic [31:0] data_in_reg;
  logic        wb_error_reg, wb_error_next;

  logic        eff_dest;
  logic        issue_accept;
  logic        alu_grant, lsu_grant, grant;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;
  logic        commit, commit_hit, commit_dec;

  // Writes to x0 are not real destinations: they never set busy or count.
  assign eff_dest = issue_rd_write && (issue_rd != 5'd0);

  always_comb begin
    issue_ready = !busy_reg[issue_rs1] && !busy_reg[issue_rs2]
                  && !(eff_dest && busy_reg[issue_rd])
                  && !(eff_dest && (outstanding_reg == MAX_CNT));
  end

  assign issue_accept = issue_valid && issue_ready && eff_dest;

  // Writeback arbitration. The pointer moves only when both sides contend,
  // so a lone producer never disturbs the fairness order.
  always_comb begin
    alu_grant   = 1'b0;
    lsu_grant   = 1'b0;
    rr_ptr_next = rr_ptr_reg;
    if (PRIORITY_MODE == 1) begin
      lsu_grant = lsu_wb_valid;
      alu_grant = alu_wb_valid && !lsu_wb_valid;
    end else if (alu_wb_valid && lsu_wb_valid) begin
      if (!rr_ptr_reg) begin
        alu_grant   = 1'b1;
        rr_ptr_next = 1'b1;
      end else begin
        lsu_grant   = 1'b1;
        rr_ptr_next = 1'b0;
      end
    end else begin
      alu_grant = alu_wb_valid;
      lsu_grant = lsu_wb_valid;
    end
  end

  assign alu_wb_ready = alu_grant;
  assign lsu_wb_ready = lsu_grant;
  assign grant        = alu_grant || lsu_grant;
  assign grant_rd     = lsu_grant ? lsu_wb_rd   : alu_wb_rd;
  assign grant_data   = lsu_grant ? lsu_wb_data : alu_wb_data;

  // Commit happens at the edge ending the cycle the write port is active.
  // A write to a register that is not busy is still performed, but it is
  // flagged and does not touch the counter, so the counter cannot underflow.
  assign commit     = write_enable_reg;
  assign commit_hit = busy_reg[write_select_reg];
  assign commit_dec = commit && commit_hit && (outstanding_reg != 4'd0);

  always_comb begin
    busy_next = busy_reg;
    if (commit && commit_hit) begin
      busy_next[write_select_reg] = 1'b0;
    end
    // An issue cannot target a busy register, so set and clear never collide
    // on a legitimately tracked register.
    if (issue_accept) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({issue_accept, commit_dec})
      2'b10:   outstanding_next = outstanding_reg + 4'd1;
      2'b01:   outstanding_next = outstanding_reg - 4'd1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  assign wb_error_next = wb_error_reg || (commit && !commit_hit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg         <= 32'd0;
      outstanding_reg  <= 4'd0;
      rr_ptr_reg       <= 1'b0;
      write_enable_reg <= 1'b0;
      write_select_reg <= 5'd0;
      data_in_reg      <= 32'd0;
      wb_error_reg     <= 1'b0;
    end else begin
      busy_reg        <= busy_next;
      outstanding_reg <= outstanding_next;
      rr_ptr_reg      <= rr_ptr_next;
      wb_error_reg    <= wb_error_next;
      // A granted write to x0 is consumed but never reaches the port;
      // select/data keep their last values whenever the port is idle.
      write_enable_reg <= grant && (grant_rd != 5'd0);
      if (grant && (grant_rd != 5'd0)) begin
        write_select_reg <= grant_rd;
        data_in_reg      <= grant_data;
      end
    end
  end

  assign write_enable = write_enable_reg;
  assign write_select = write_select_reg;
  assign data_in      = data_in_reg;
  assign busy         = busy_reg;
  assign outstanding  = outstanding_reg;
  assign wb_error     = wb_error_reg;

endmodule
